// File: rtl/ifetch_queue_if.sv
// Fetch-side memory handshake plus the decode-facing head-of-queue signals.
// The master modport is the prefetch queue; the slave modport is memory plus decode.
interface ifetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pcadd4;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, pcadd4,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, stall
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, pcadd4,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, stall
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: in-order fetch requests with credit-based flow control,
// a circular buffer of {inst, pc+4}, and redirect flush with stale-response discard.
module ifetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input logic            clk,
    input logic            rst,
    ifetch_queue_if.master bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    typedef logic [CntW-1:0] cnt_t;
    localparam cnt_t DepthCnt = cnt_t'(DEPTH);

    logic [31:0]     fetchPc_q, respPc_q;
    cnt_t            occ_q, outst_q, discard_q;
    logic [PtrW-1:0] rdPtr_q, wrPtr_q;
    logic [31:0]     instMem [DEPTH];
    logic [31:0]     pcMem   [DEPTH];

    logic        fire, enq, deq, rsp;
    cnt_t        inFlight;
    logic [31:0] redirPc;

    // occ + outst never exceeds DEPTH, so the sum fits the counter width.
    assign inFlight = occ_q + outst_q;
    assign redirPc  = bus.redirect_pc & 32'hFFFF_FFFC;
    assign rsp      = bus.imem_rvalid;

    assign bus.imem_req   = !rst && !bus.redirect && (inFlight < DepthCnt);
    assign bus.imem_addr  = fetchPc_q;
    assign bus.inst_valid = (occ_q != '0);
    assign bus.inst       = bus.inst_valid ? instMem[rdPtr_q] : 32'h0;
    assign bus.pcadd4     = bus.inst_valid ? pcMem[rdPtr_q] : 32'h0;

    assign fire = bus.imem_req && bus.imem_gnt;
    assign enq  = rsp && (discard_q == '0) && !bus.redirect;
    assign deq  = bus.inst_valid && !bus.stall && !bus.redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetchPc_q <= RESET_PC;
            respPc_q  <= RESET_PC;
            occ_q     <= '0;
            outst_q   <= '0;
            discard_q <= '0;
            rdPtr_q   <= '0;
            wrPtr_q   <= '0;
        end else if (bus.redirect) begin
            occ_q     <= '0;
            rdPtr_q   <= wrPtr_q;
            fetchPc_q <= redirPc;
            respPc_q  <= redirPc;
            // Already-stale responses are a subset of outst, so every remaining
            // in-flight response becomes stale.
            outst_q   <= outst_q - cnt_t'(rsp);
            discard_q <= outst_q - cnt_t'(rsp);
        end else begin
            if (fire) begin
                fetchPc_q <= fetchPc_q + 32'd4;
            end
            outst_q <= outst_q + cnt_t'(fire) - cnt_t'(rsp);
            if (rsp && (discard_q != '0)) begin
                discard_q <= discard_q - cnt_t'(1);
            end
            if (enq) begin
                wrPtr_q  <= wrPtr_q + 1'b1;
                respPc_q <= respPc_q + 32'd4;
            end
            if (deq) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            occ_q <= occ_q + cnt_t'(enq) - cnt_t'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            instMem[wrPtr_q] <= bus.imem_rdata;
            pcMem[wrPtr_q]   <= respPc_q + 32'd4;
        end
    end

    // A response into a full queue means memory ignored the credit limit.
    a_noOverflow: assert property (@(posedge clk) disable iff (rst)
        !(bus.imem_rvalid && (occ_q == DepthCnt)));
endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model of the fetch stream.
module tb_ifetch_queue;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc4;
    } ent_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ifetch_queue_if bus ();

    ifetch_queue #(
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    req_t        memQ[$];
    ent_t        instQ[$];
    logic [31:0] expFetch;
    logic [31:0] salt;
    int          cyc;
    int          errors;
    int          checks;
    int unsigned minLat, maxLat, rvProb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, then advance both.
    task automatic step(input bit st, input bit rd, input logic [31:0] rpc, input bit gnt);
        bit          rv;
        bit          expReq;
        logic [31:0] rdata;
        req_t        r;
        rv    = (memQ.size() > 0) && (memQ[0].due <= cyc) && ($urandom_range(99) < rvProb);
        rdata = rv ? (memQ[0].addr ^ salt) : $urandom();
        bus.stall       = st;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.imem_gnt    = gnt;
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rdata;
        #1;
        expReq = !rd && ((instQ.size() + memQ.size()) < DEPTH);
        check("imem_req", 32'(bus.imem_req), 32'(expReq));
        check("imem_addr", bus.imem_addr, expFetch);
        check("inst_valid", 32'(bus.inst_valid), 32'(instQ.size() > 0));
        check("inst", bus.inst, (instQ.size() > 0) ? instQ[0].inst : 32'h0);
        check("pcadd4", bus.pcadd4, (instQ.size() > 0) ? instQ[0].pc4 : 32'h0);
        @(posedge clk);
        if (rd) begin
            if (rv) void'(memQ.pop_front());
            foreach (memQ[i]) memQ[i].stale = 1'b1;
            instQ.delete();
            expFetch = {rpc[31:2], 2'b00};
        end else begin
            if ((instQ.size() > 0) && !st) void'(instQ.pop_front());
            if (rv) begin
                r = memQ.pop_front();
                if (!r.stale) instQ.push_back('{inst: rdata, pc4: r.addr + 32'd4});
            end
            if (expReq && gnt) begin
                memQ.push_back('{addr: expFetch, stale: 1'b0,
                                 due: cyc + int'($urandom_range(maxLat, minLat))});
                expFetch = expFetch + 32'd4;
            end
        end
        cyc++;
        #1;
    endtask

    // Reset asserted between clock edges; outputs must clear without an edge.
    task automatic doReset();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.redirect    = 1'b0;
        bus.stall       = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_req", 32'(bus.imem_req), 32'h0);
        check("rst_addr", bus.imem_addr, RESET_PC);
        check("rst_valid", 32'(bus.inst_valid), 32'h0);
        check("rst_inst", bus.inst, 32'h0);
        check("rst_pcadd4", bus.pcadd4, 32'h0);
        memQ.delete();
        instQ.delete();
        expFetch = RESET_PC;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        salt   = 32'h0;
        minLat = 1;
        maxLat = 1;
        rvProb = 100;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.stall       = 1'b0;
        rst = 1'b0;
        #2;
        doReset();

        // Streaming with a 1-cycle memory that always grants.
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Stall from reset: head holds 0x3000 and requests stop at the credit limit.
        doReset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
        check("stall_head", bus.inst, 32'h0000_3000);
        check("stall_req", 32'(bus.imem_req), 32'h0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Grant withheld for 3 cycles.
        doReset();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            check("gnt_low_addr", bus.imem_addr, 32'h0000_3008);
        end
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // 3-cycle memory, two requests in flight, then redirect to an unaligned target.
        doReset();
        minLat = 3;
        maxLat = 3;
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h0000_3101, 1'b1);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 16 && !seen; i++) begin
                step(1'b1, 1'b0, 32'h0, 1'b1);
                seen = bus.inst_valid;
            end
            check("redir_seen", 32'(seen), 32'h1);
            check("redir_inst", bus.inst, 32'h0000_3100);
            check("redir_pcadd4", bus.pcadd4, 32'h0000_3104);
        end
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect in the same cycle as a response, stalled with three entries queued.
        doReset();
        minLat = 1;
        maxLat = 1;
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 20 && !hit; i++) begin
                hit = (instQ.size() == 3) && (memQ.size() > 0) && (memQ[0].due <= cyc);
                if (!hit) step(1'b1, 1'b0, 32'h0, 1'b1);
            end
            check("occ3_reached", 32'(hit), 32'h1);
        end
        step(1'b1, 1'b1, 32'h0000_3200, 1'b1);
        check("flush_valid", 32'(bus.inst_valid), 32'h0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Reset mid-stream with two queued and two in flight.
        doReset();
        minLat = 3;
        maxLat = 3;
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 20 && !hit; i++) begin
                hit = (instQ.size() == 2) && (memQ.size() == 2);
                if (!hit) step(1'b1, 1'b0, 32'h0, 1'b1);
            end
            check("mid_state_reached", 32'(hit), 32'h1);
        end
        check("pre_rst_valid", 32'(bus.inst_valid), 32'h1);
        doReset();
        minLat = 1;
        maxLat = 1;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Randomized traffic: variable latency, sparse grants/responses, stalls, redirects.
        doReset();
        salt   = $urandom();
        minLat = 1;
        maxLat = 4;
        rvProb = 70;
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(99) < 30, $urandom_range(99) < 4, $urandom(),
                 $urandom_range(99) < 70);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
